// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings and the
// elastic-buffer state type.
package ext_pkg;

    localparam int EOP_W = 3;

    localparam logic [EOP_W-1:0] EXT_SIGN     = 3'b000;
    localparam logic [EOP_W-1:0] EXT_ZERO     = 3'b001;
    localparam logic [EOP_W-1:0] EXT_UPPER    = 3'b010;
    localparam logic [EOP_W-1:0] EXT_ZERO_SL2 = 3'b011;
    localparam logic [EOP_W-1:0] EXT_SIGN_SL2 = 3'b100;
    localparam logic [EOP_W-1:0] EXT_NOT      = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: widens imm to DATA_W bits under eop,
// flagging the two unused mode codes.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [IMM_W-1:0]  imm,
    input  logic [EOP_W-1:0]  eop,
    output logic [DATA_W-1:0] ext,
    output logic              err
);

    localparam int PAD_W = DATA_W - IMM_W;

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;

    assign zext = {{PAD_W{1'b0}}, imm};
    assign sext = {{PAD_W{imm[IMM_W-1]}}, imm};

    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        ext = '0;
        err = 1'b0;
        case (eop)
            EXT_SIGN:     ext = sext;
            EXT_ZERO:     ext = zext;
            EXT_UPPER:    ext = {imm, {PAD_W{1'b0}}};
            EXT_ZERO_SL2: ext = zext << 2;
            EXT_SIGN_SL2: ext = sext << 2;
            EXT_NOT:      ext = ~zext;
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Registered immediate extender with valid/ready on both sides and a
// two-entry elastic buffer (main register drives outputs, skid absorbs stalls).
module ext_unit
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IMM_W-1:0]    imm,
    input  logic [EOP_W-1:0]    eop,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   ext,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic [DATA_W-1:0]   core_ext;
    logic                core_err;
    logic                in_xfer;
    logic                out_xfer;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_ext_q, main_ext_d;
    logic                main_err_q, main_err_d;
    logic [DATA_W-1:0]   skid_ext_q, skid_ext_d;
    logic                skid_err_q, skid_err_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .imm (imm),
        .eop (eop),
        .ext (core_ext),
        .err (core_err)
    );

    // Handshake flags come from the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    assign ext     = main_ext_q;
    assign err     = main_err_q;
    assign err_cnt = err_cnt_q;

    always_comb begin
        state_d    = state_q;
        main_ext_d = main_ext_q;
        main_err_d = main_err_q;
        skid_ext_d = skid_ext_q;
        skid_err_d = skid_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_ext_d = core_ext;
                    main_err_d = core_err;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    skid_ext_d = core_ext;
                    skid_err_d = core_err;
                    state_d    = ST_FULL;
                end else if (in_xfer) begin
                    main_ext_d = core_ext;
                    main_err_d = core_err;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    main_ext_d = skid_ext_q;
                    main_err_d = skid_err_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_xfer && core_err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            // NOTE: data registers are reset too, so ext reads zero and no
            // stale result survives a reset inside the buffer.
            main_ext_q <= '0;
            main_err_q <= 1'b0;
            skid_ext_q <= '0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            main_ext_q <= main_ext_d;
            main_err_q <= main_err_d;
            skid_ext_q <= skid_ext_d;
            skid_err_q <= skid_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_ext_unit.sv
// Self-checking bench for ext_unit: queue-based reference model checked every
// cycle, plus literal expectations for modes, saturation and narrow params.
module tb_ext_unit;

    typedef struct {
        logic        err;
        logic [63:0] val;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] imm = '0;
    logic [2:0]  eop = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ext;
    logic        err;
    logic [7:0]  err_cnt;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [7:0]  imm2 = '0;
    logic [2:0]  eop2 = '0;
    logic        out_valid2;
    logic [15:0] ext2;
    logic        err2;
    logic [1:0]  err_cnt2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pops = 0;
    int exp_cnt = 0;
    res_t q[$];

    logic [31:0] mode_exp [6] = '{32'hFFFF8001, 32'h00008001, 32'h80010000,
                                  32'h00020004, 32'hFFFE0004, 32'hFFFF7FFE};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ext_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .eop       (eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext       (ext),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    ext_unit #(.IMM_W(8), .DATA_W(16), .ERRCNT_W(2)) dut_narrow (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .imm       (imm2),
        .eop       (eop2),
        .out_valid (out_valid2),
        .out_ready (1'b1),
        .ext       (ext2),
        .err       (err2),
        .err_cnt   (err_cnt2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from the mode definitions using plain integer arithmetic.
    function automatic res_t ref_ext(input int iw, input int dw, input longint unsigned im, input int e);
        res_t r;
        longint unsigned mask = (64'd1 << dw) - 1;
        longint unsigned ui   = im & ((64'd1 << iw) - 1);
        longint          si;
        longint unsigned v;
        si = (ui >= (64'd1 << (iw - 1))) ? longint'(ui) - longint'(64'd1 << iw) : longint'(ui);
        r.err = 1'b0;
        case (e)
            0: v = longint'(si);
            1: v = ui;
            2: v = ui * (64'd1 << (dw - iw));
            3: v = ui * 4;
            4: v = longint'(si * 4);
            5: v = mask - ui;
            default: begin v = 0; r.err = 1'b1; end
        endcase
        r.val = v & mask;
        return r;
    endfunction

    always @(negedge rst_n) begin
        q.delete();
        exp_cnt = 0;
    end

    // Per-cycle compare against the FIFO model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            check("err_cnt", err_cnt, exp_cnt);
            if (out_valid && q.size() > 0) begin
                check("ext", ext, q[0].val);
                check("err", err, q[0].err);
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (in_valid && in_ready) begin
                res_t r;
                r = ref_ext(16, 32, imm, eop);
                q.push_back(r);
                if (r.err && exp_cnt < 255) exp_cnt++;
            end
        end
    end

    task automatic send(input logic [15:0] i, input logic [2:0] e);
        int n = 0;
        in_valid = 1'b1;
        imm = i;
        eop = e;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", out_valid, 0);
    endtask

    task automatic send2(input logic [7:0] i, input logic [2:0] e);
        in_valid2 = 1'b1;
        imm2 = i;
        eop2 = e;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ext", ext, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;

        // All legal modes on imm=8001, one cycle latency each.
        for (int m = 0; m < 6; m++) begin
            send(16'h8001, 3'(m));
            check("mode_ext", ext, mode_exp[m]);
            check("mode_err", err, 0);
            check("mode_valid", out_valid, 1);
        end

        send(16'h1234, 3'b110);
        check("ill6_ext", ext, 0);
        check("ill6_err", err, 1);
        send(16'hABCD, 3'b111);
        check("ill7_ext", ext, 0);
        check("ill7_err", err, 1);
        check("ill_cnt", err_cnt, 2);
        drain();

        // Back-pressure: two held, third waits until the stall clears.
        out_ready = 1'b0;
        send(16'd1, 3'b001);
        send(16'd2, 3'b001);
        check("bp_in_ready", in_ready, 0);
        check("bp_ext_hold", ext, 1);
        @(posedge clk);
        #1;
        check("bp_ext_stable", ext, 1);
        check("bp_valid_stable", out_valid, 1);
        out_ready = 1'b1;
        send(16'd3, 3'b001);
        check("bp_last", ext, 3);
        drain();

        // Full throughput.
        begin
            int c0, p0;
            c0 = cyc;
            p0 = pops;
            for (int k = 0; k < 100; k++) send(16'($urandom), 3'($urandom_range(0, 7)));
            check("tput_cycles", cyc - c0, 100);
            @(negedge clk);
            #1;
            check("tput_outputs", pops - p0, 100);
        end
        drain();

        // Random valid/ready traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid = 1'($urandom);
            imm = 16'($urandom);
            eop = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // Narrow parameter set.
        send2(8'hC3, 3'b100);
        check("narrow_sl2", ext2, 16'hFF0C);
        send2(8'hC3, 3'b010);
        check("narrow_upper", ext2, 16'hC300);
        for (int k = 0; k < 5; k++) begin
            send2(8'($urandom), 3'b110);
            check("narrow_ill_err", err2, 1);
            check("narrow_ill_ext", ext2, 0);
            check("narrow_sat", err_cnt2, (k + 1 < 3) ? k + 1 : 3);
        end

        // Reset mid-operation from FULL.
        out_ready = 1'b0;
        send(16'h00AA, 3'b110);
        send(16'h0055, 3'b000);
        check("pre_rst_full", in_ready, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_cnt", err_cnt, 0);
        check("mid_rst_ext", ext, 0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", out_valid, 0);
        end
        send(16'h7FFF, 3'b100);
        check("post_rst_ext", ext, 32'h0001FFFC);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
# ext_unit

Parametrised, pipelined immediate extender for the datapath's decode stage. It replaces the combinational extender with a registered, back-pressure-aware unit. It widens an IMM_W-bit immediate to DATA_W bits under one of six modes, and flags illegal mode codes. It sits between instruction decode and operand select, with a valid/ready handshake on both sides and a two-entry elastic buffer.

## Interface
Parameters:
- IMM_W, 16, immediate width; must be at least 2.
- DATA_W, 32, output width; must be at least IMM_W+2.
- ERRCNT_W, 8, width of the illegal-mode counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents imm/eop.
- in_ready  output  1  unit can accept; registered.
- imm  input  IMM_W  raw immediate.
- eop  input  3  extension mode.
- out_valid  output  1  ext/err valid.
- out_ready  input  1  downstream accepts.
- ext  output  DATA_W  extended result.
- err  output  1  result came from an illegal eop.
- err_cnt  output  ERRCNT_W  saturating count of accepted illegal eops.

## Operation
- Modes (eop):
  - 000 sign-extend.
  - 001 zero-extend.
  - 010 upper: imm placed in bits [DATA_W-1:DATA_W-IMM_W], low bits zero.
  - 011 zero-extend then shift left 2.
  - 100 sign-extend then shift left 2 (branch offset).
  - 101 all-ones mask of imm: ~zero-extend(imm).
  - 110 and 111 are illegal: ext=0 and err=1.
- Shift-left-2 results are truncated to DATA_W; the two MSBs of the extended value are dropped.
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- Storage is a main register (drives outputs) plus a skid register. State machine:
  - EMPTY: main and skid empty.
  - ONE: main full.
  - FULL: main and skid full.
- Transitions:
  - EMPTY + in transfer -> ONE.
  - ONE + in transfer, no out transfer -> FULL; the new data goes to skid.
  - ONE + in and out transfer -> ONE; main reloads with the new data.
  - ONE + out transfer only -> EMPTY.
  - FULL + out transfer -> ONE; skid moves into main.
- Each result is computed from imm/eop at its in transfer and stored with its err bit.
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- err_cnt increments on every in transfer with illegal eop. It saturates at all-ones and never wraps.
- Order is strictly FIFO; no result is dropped or duplicated.

## Timing
- Reset values (asynchronous, while rst_n=0): state EMPTY, out_valid 0, in_ready 1, ext 0, err 0, err_cnt 0, skid cleared.
- Reset mid-operation discards all held results immediately. The first cycle after rst_n rises behaves as EMPTY.
- Latency: 1 cycle. Data transferred at edge N is on ext with out_valid=1 after edge N, when main was empty or drained at the same edge.
- Throughput: 1 result/cycle when out_ready is held high.
- in_ready depends only on registered state; there is no combinational path from out_ready to in_ready.
- While out_valid=1 and out_ready=0, ext/err/out_valid hold stable.
- In FULL, in_valid is ignored; imm/eop may change freely.

## Structure
- Shared package ext_pkg holds:
  - eop encodings as localparams: EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_ZERO_SL2, EXT_SIGN_SL2, EXT_NOT.
  - the eop width constant (3).
- One combinational sub-module, ext_core (imm, eop -> ext, err), is instantiated once at the input side. The top holds only the state machine, registers and counter.

## Test plan
- Modes, default params, out_ready=1, imm=16'h8001:
  - eop 000 -> 32'hFFFF8001.
  - eop 001 -> 32'h00008001.
  - eop 010 -> 32'h80010000.
  - eop 011 -> 32'h00020004.
  - eop 100 -> 32'hFFFE0004.
  - eop 101 -> 32'hFFFF7FFE.
  - Each result appears one cycle after its transfer, with err=0.
- Illegal: eop 110 then 111 -> ext=0 with err=1 both times, and err_cnt=2. Preload with ERRCNT_W=2 and send 5 illegal ops -> err_cnt stays at 3.
- Back-pressure: out_ready=0 and stream imm 1,2,3 with eop 001.
  - After two transfers, in_ready=0 and ext holds 1.
  - Raise out_ready -> outputs 1,2,3 in order, with no loss.
- Full throughput: out_ready=1 and 100 back-to-back random transfers -> 100 outputs on consecutive cycles, each matching a reference model.
- Reset mid-operation: reach FULL, then pulse rst_n low between clock edges -> out_valid=0, in_ready=1, err_cnt=0 immediately, with no stale output afterwards.
- Parameter sweep: IMM_W=8, DATA_W=16, imm=8'hC3.
  - eop 100 -> 16'hFF0C.
  - eop 010 -> 16'hC300.
